// File: rtl/nes_button_events_pkg.sv
// Shared constants and types for the NES button event unit.
// Button indices, event kind encodings and the scan FSM state type.
package nes_pkg;

    localparam logic [2:0] BTN_A      = 3'd0;
    localparam logic [2:0] BTN_B      = 3'd1;
    localparam logic [2:0] BTN_SELECT = 3'd2;
    localparam logic [2:0] BTN_START  = 3'd3;
    localparam logic [2:0] BTN_UP     = 3'd4;
    localparam logic [2:0] BTN_DOWN   = 3'd5;
    localparam logic [2:0] BTN_LEFT   = 3'd6;
    localparam logic [2:0] BTN_RIGHT  = 3'd7;

    localparam logic [1:0] EVT_PRESS   = 2'b00;
    localparam logic [1:0] EVT_RELEASE = 2'b01;
    localparam logic [1:0] EVT_REPEAT  = 2'b10;

    localparam int EVT_W = 5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    function automatic logic [EVT_W-1:0] evt_pack(
        input logic [1:0] kind,
        input logic [2:0] idx
    );
        return {kind, idx};
    endfunction

endpackage

// File: rtl/nes_button_events_if.sv
// Poll input and event-queue port bundle of the button event unit.
// slave = event unit side, master = poller/consumer side.
interface nes_button_events_if #(
    parameter int FIFO_DEPTH = 8
);
    import nes_pkg::*;

    logic [7:0]                   buttons;
    logic                         buttons_valid;
    logic [EVT_W-1:0]             evt_data;
    logic                         evt_valid;
    logic                         evt_ready;
    logic [$clog2(FIFO_DEPTH):0]  evt_count;
    logic [7:0]                   held;
    logic                         overflow;
    logic                         clear_overflow;

    modport slave (
        input  buttons, buttons_valid, evt_ready, clear_overflow,
        output evt_data, evt_valid, evt_count, held, overflow
    );

    modport master (
        output buttons, buttons_valid, evt_ready, clear_overflow,
        input  evt_data, evt_valid, evt_count, held, overflow
    );

endinterface

// File: rtl/nes_button_events_fifo.sv
// First-word-fall-through FIFO with a registered occupancy counter.
// A push into a full queue succeeds only when a pop frees a slot that cycle.
module event_fifo #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_drop
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!o_full || w_pop);
    assign o_drop  = i_push && !w_push;
    assign o_count = r_count;
    assign o_data  = o_empty ? '0 : r_mem[r_rd];

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr] <= i_data;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop)  r_rd <= r_rd + 1'b1;
            if (w_push && !w_pop)
                r_count <= r_count + CW'(1);
            else if (w_pop && !w_push)
                r_count <= r_count - CW'(1);
        end
    end

endmodule

// File: rtl/nes_button_events.sv
// Turns per-poll NES button snapshots into queued press/release/repeat
// events, scanning one button index per cycle after each accepted poll.
module nes_button_events
    import nes_pkg::*;
#(
    parameter int         REPEAT_DELAY = 30,
    parameter int         REPEAT_RATE  = 6,
    parameter logic [7:0] REPEAT_MASK  = 8'hF0,
    parameter int         FIFO_DEPTH   = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    nes_button_events_if.slave   bus
);
    localparam int CW = $clog2(REPEAT_DELAY + REPEAT_RATE + 1);
    localparam logic [CW-1:0] C_DLY = CW'(REPEAT_DELAY);
    localparam logic [CW-1:0] C_TOP = CW'(REPEAT_DELAY + REPEAT_RATE);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [2:0]       r_idx;
    logic [7:0]       r_held;
    logic [7:0]       r_press;
    logic [7:0]       r_rel;
    logic [7:0]       r_rpt;
    logic [CW-1:0]    r_cnt;
    logic             r_ovf;

    logic             w_accept;
    logic             w_push;
    logic [1:0]       w_kind;
    logic [7:0]       w_m;
    logic [7:0]       w_rpt;
    logic [CW-1:0]    w_cnt_nxt;
    logic [CW-1:0]    w_cnt_inc;
    logic             w_drop;
    logic             w_ovf_set;

    // Repeat counter only tracks the masked buttons held unchanged.
    always_comb begin
        w_m       = bus.buttons & REPEAT_MASK;
        w_cnt_inc = r_cnt + CW'(1);
        w_cnt_nxt = '0;
        w_rpt     = '0;
        if (w_m != '0 && w_m == (r_held & REPEAT_MASK)) begin
            w_cnt_nxt = w_cnt_inc;
            if (w_cnt_inc == C_DLY) begin
                w_rpt = w_m;
            end else if (w_cnt_inc == C_TOP) begin
                w_rpt     = w_m;
                w_cnt_nxt = C_DLY;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_push      = 1'b0;
        w_kind      = EVT_PRESS;
        unique case (r_state)
            ST_IDLE: begin
                if (bus.buttons_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (r_press[r_idx]) begin
                    w_push = 1'b1;
                    w_kind = EVT_PRESS;
                end else if (r_rel[r_idx]) begin
                    w_push = 1'b1;
                    w_kind = EVT_RELEASE;
                end else if (r_rpt[r_idx]) begin
                    w_push = 1'b1;
                    w_kind = EVT_REPEAT;
                end
                if (r_idx == 3'd7) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_ovf_set = w_drop ||
                       (r_state == ST_SCAN && bus.buttons_valid);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_held  <= '0;
            r_press <= '0;
            r_rel   <= '0;
            r_rpt   <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_press <= bus.buttons & ~r_held;
                r_rel   <= ~bus.buttons & r_held;
                r_rpt   <= w_rpt;
                r_held  <= bus.buttons;
                r_cnt   <= w_cnt_nxt;
                r_idx   <= '0;
            end else if (r_state == ST_SCAN) begin
                r_idx <= r_idx + 3'd1;
            end
            if (w_ovf_set)
                r_ovf <= 1'b1;
            else if (bus.clear_overflow)
                r_ovf <= 1'b0;
        end
    end

    event_fifo #(
        .WIDTH (EVT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (clock),
        .i_rst   (reset),
        .i_push  (w_push),
        .i_data  (evt_pack(w_kind, r_idx)),
        .i_pop   (bus.evt_ready),
        .o_data  (bus.evt_data),
        .o_full  (),
        .o_empty (),
        .o_count (bus.evt_count),
        .o_drop  (w_drop)
    );

    assign bus.evt_valid = (bus.evt_count != '0);
    assign bus.held      = r_held;
    assign bus.overflow  = r_ovf;

endmodule

// File: tb/tb_nes_button_events.sv
// Scoreboard bench for nes_button_events (REPEAT_DELAY=3, REPEAT_RATE=2).
// Stimulus queues expected events; a negedge monitor checks every pop.
module tb_nes_button_events;
    import nes_pkg::*;

    logic clock = 1'b0;
    logic reset;

    int n_tests = 0;
    int n_fail  = 0;

    logic [4:0] sb[$];

    nes_button_events_if #(.FIFO_DEPTH(8)) bus ();

    nes_button_events #(
        .REPEAT_DELAY (3),
        .REPEAT_RATE  (2),
        .REPEAT_MASK  (8'hF0),
        .FIFO_DEPTH   (8)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Inputs only change at posedge+1, so a pop seen here happens next edge.
    always @(negedge clock) begin
        if (!reset && bus.evt_valid && bus.evt_ready) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL pop: got %0h expected no event",
                         bus.evt_data);
            end else begin
                logic [4:0] e;
                e = sb.pop_front();
                if (bus.evt_data !== e) begin
                    n_fail++;
                    $display("FAIL pop: got %0h expected %0h",
                             bus.evt_data, e);
                end
            end
        end
    end

    task automatic expect_evt(input logic [4:0] e);
        sb.push_back(e);
    endtask

    task automatic start_poll(input logic [7:0] b);
        @(posedge clock); #1;
        bus.buttons       = b;
        bus.buttons_valid = 1'b1;
        @(posedge clock); #1;
        bus.buttons_valid = 1'b0;
    endtask

    task automatic poll(input logic [7:0] b);
        start_poll(b);
        repeat (8) @(posedge clock);
        #1;
    endtask

    task automatic drain(input string nm);
        int k;
        k = 0;
        while ((sb.size() != 0 || bus.evt_valid) && k < 300) begin
            @(posedge clock);
            k++;
        end
        #1;
        check(nm, {31'd0, (sb.size() == 0 && !bus.evt_valid)}, 32'd1);
    endtask

    task automatic pulse_clear();
        @(posedge clock); #1;
        bus.clear_overflow = 1'b1;
        @(posedge clock); #1;
        bus.clear_overflow = 1'b0;
    endtask

    logic [7:0] t3_btn [13] = '{8'h10, 8'h10, 8'h10, 8'h10,
                                8'h11, 8'h11, 8'h11, 8'h11,
                                8'h21, 8'h21, 8'h21, 8'h21, 8'h00};
    int         t3_n   [13] = '{2, 0, 0, 1, 1, 1, 0, 1, 2, 0, 0, 1, 2};
    logic [4:0] t3_e0  [13] = '{5'h09, 5'h00, 5'h00, 5'h14,
                                5'h00, 5'h14, 5'h00, 5'h14,
                                5'h0C, 5'h00, 5'h00, 5'h15, 5'h08};
    logic [4:0] t3_e1  [13] = '{5'h04, 5'h00, 5'h00, 5'h00,
                                5'h00, 5'h00, 5'h00, 5'h00,
                                5'h05, 5'h00, 5'h00, 5'h00, 5'h0D};

    initial begin
        reset              = 1'b1;
        bus.buttons        = '0;
        bus.buttons_valid  = 1'b0;
        bus.evt_ready      = 1'b0;
        bus.clear_overflow = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_held",  {24'd0, bus.held}, 32'h0);
        check("rst_valid", {31'd0, bus.evt_valid}, 32'h0);
        check("rst_count", {28'd0, bus.evt_count}, 32'h0);
        check("rst_data",  {27'd0, bus.evt_data}, 32'h0);
        check("rst_ovf",   {31'd0, bus.overflow}, 32'h0);
        reset = 1'b0;

        // single press then release of A
        bus.evt_ready = 1'b1;
        expect_evt(evt_pack(EVT_PRESS, BTN_A));
        start_poll(8'h01);
        check("t1_held1", {24'd0, bus.held}, 32'h01);
        @(posedge clock); #1;
        check("t1_valid", {31'd0, bus.evt_valid}, 32'h1);
        check("t1_data",  {27'd0, bus.evt_data}, 32'h00);
        check("t1_count", {28'd0, bus.evt_count}, 32'h1);
        repeat (7) @(posedge clock);
        #1;
        expect_evt(5'h08);
        poll(8'h00);
        check("t1_held0", {24'd0, bus.held}, 32'h00);
        drain("t1_drain");

        // fill the queue, then overflow it
        bus.evt_ready = 1'b0;
        for (int i = 0; i < 8; i++) expect_evt(5'(i));
        poll(8'hFF);
        check("t2_count", {28'd0, bus.evt_count}, 32'h8);
        check("t2_ovf0",  {31'd0, bus.overflow}, 32'h0);
        check("t2_head",  {27'd0, bus.evt_data}, 32'h00);
        poll(8'h00);
        check("t2_ovf1",   {31'd0, bus.overflow}, 32'h1);
        check("t2_count2", {28'd0, bus.evt_count}, 32'h8);
        check("t2_held",   {24'd0, bus.held}, 32'h00);
        pulse_clear();
        check("t2_clr", {31'd0, bus.overflow}, 32'h0);

        // full queue: simultaneous push and pop
        expect_evt(5'h00);
        start_poll(8'h01);
        bus.evt_ready = 1'b1;
        @(posedge clock); #1;
        check("t4_count", {28'd0, bus.evt_count}, 32'h8);
        check("t4_ovf",   {31'd0, bus.overflow}, 32'h0);
        repeat (7) @(posedge clock);
        #1;
        drain("t4_drain");
        check("t4_ovf2", {31'd0, bus.overflow}, 32'h0);

        // poll arriving mid-scan is dropped
        expect_evt(5'h08);
        expect_evt(5'h01);
        start_poll(8'h02);
        @(posedge clock); #1;
        bus.buttons       = 8'h80;
        bus.buttons_valid = 1'b1;
        @(posedge clock); #1;
        bus.buttons_valid = 1'b0;
        repeat (6) @(posedge clock);
        #1;
        check("t5_held", {24'd0, bus.held}, 32'h02);
        check("t5_ovf",  {31'd0, bus.overflow}, 32'h1);
        pulse_clear();
        drain("t5_drain");

        // auto-repeat timing
        for (int p = 0; p < 13; p++) begin
            if (t3_n[p] > 0) expect_evt(t3_e0[p]);
            if (t3_n[p] > 1) expect_evt(t3_e1[p]);
            poll(t3_btn[p]);
            drain($sformatf("t3_poll%0d", p + 1));
        end
        check("t3_held", {24'd0, bus.held}, 32'h00);

        // reset in the middle of a scan
        bus.evt_ready = 1'b0;
        start_poll(8'h07);
        @(posedge clock); #1;
        bus.buttons       = 8'hF0;
        bus.buttons_valid = 1'b1;
        @(posedge clock); #1;
        bus.buttons_valid = 1'b0;
        @(posedge clock); #1;
        check("t6_count3", {28'd0, bus.evt_count}, 32'h3);
        check("t6_ovf1",   {31'd0, bus.overflow}, 32'h1);
        check("t6_held",   {24'd0, bus.held}, 32'h07);
        reset = 1'b1;
        #1;
        check("t6_valid", {31'd0, bus.evt_valid}, 32'h0);
        check("t6_count", {28'd0, bus.evt_count}, 32'h0);
        check("t6_held0", {24'd0, bus.held}, 32'h0);
        check("t6_ovf0",  {31'd0, bus.overflow}, 32'h0);
        check("t6_data",  {27'd0, bus.evt_data}, 32'h0);
        @(posedge clock);
        @(posedge clock); #1;
        reset         = 1'b0;
        bus.evt_ready = 1'b1;
        expect_evt(5'h00);
        expect_evt(5'h07);
        poll(8'h81);
        check("t6_held2", {24'd0, bus.held}, 32'h81);
        expect_evt(5'h08);
        expect_evt(5'h0F);
        poll(8'h00);
        drain("t6_drain");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
